// File: rtl/i2c_write_seq.sv
// i2c_write_seq: I2C master write sequencer.
//
// Sends START, then 1..MAX_PACKETS bytes taken from flat_i2c_data (byte 0 in the top byte
// lane, sent first, carrying address + R/W), checks the ACK after every byte, then STOP.
// Each bus bit is split into four quarters of CLK_DIV clk cycles.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             request; accepted when sampled high in IDLE
//   packets           byte count (clamped to MAX_PACKETS; 0 gives an immediate done pulse)
//   flat_i2c_data     byte k = flat_i2c_data[(MAX_PACKETS-1-k)*8 +: 8]
//   i2c_scl_o/sda_o   open-drain drives, 1 = release, 0 = pull low
//   i2c_sda_i         SDA pin level, sampled for ACK
//   i2c_scl_i         SCL pin level, only used when I2C_CLK_STRETCH_EN is defined
//   busy              high from start acceptance until done
//   done              one-cycle pulse at the end of a transaction
//   ack_err           sticky NACK flag, cleared by the next accepted start
//
// Build option: define I2C_CLK_STRETCH_EN to let a slave stretch SCL. Without it the
// timing is purely divider based and i2c_scl_i is ignored.
//
// SCL/SDA/done are registered from the current state, so the bus lags the state by one
// cycle: the first START quarter appears on the bus one edge after acceptance.
module i2c_write_seq #(
    parameter int unsigned MAX_PACKETS = 4,
    parameter int unsigned PACKET_W    = 3,
    parameter int unsigned CLK_DIV     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PACKET_W-1:0]      packets,
    input  logic [MAX_PACKETS*8-1:0] flat_i2c_data,
    output logic                     i2c_scl_o,
    output logic                     i2c_sda_o,
    input  logic                     i2c_sda_i,
    input  logic                     i2c_scl_i,
    output logic                     busy,
    output logic                     done,
    output logic                     ack_err
);

    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DW = MAX_PACKETS * 8;
    localparam logic [TW-1:0]       TLast    = TW'(CLK_DIV - 1);
    localparam logic [PACKET_W-1:0] MaxCount = PACKET_W'(MAX_PACKETS);

    typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StDone} state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [1:0]          quarter_q, quarter_d;
    logic [2:0]          bit_q, bit_d;
    logic [PACKET_W-1:0] left_q, left_d;
    logic [DW-1:0]       data_q, data_d;
    logic                scl_q, scl_d, sda_q, sda_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                active, hold, tick, q3_tick;

    assign active  = (state_q == StStart) || (state_q == StBit) ||
                     (state_q == StAck)   || (state_q == StStop);

`ifdef I2C_CLK_STRETCH_EN
    // Released SCL still read low: a slave is stretching, so freeze the quarter timer.
    assign hold = active && scl_q && !i2c_scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = i2c_scl_i;
    assign hold = 1'b0;
`endif

    assign tick    = active && !hold && (timer_q == TLast);
    assign q3_tick = tick && (quarter_q == 2'd3);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            left_q    <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            left_q    <= left_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        left_d    = left_q;
        data_d    = data_q;
        busy_d    = busy_q;
        err_d     = err_q;

        if (!active) begin
            timer_d   = '0;
            quarter_d = '0;
        end else if (!hold) begin
            if (timer_q == TLast) begin
                timer_d   = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (packets != '0) begin
                        state_d = StStart;
                        left_d  = (packets > MaxCount) ? MaxCount : packets;
                        data_d  = flat_i2c_data;
                        bit_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StStart: if (q3_tick) state_d = StBit;
            StBit: begin
                if (q3_tick) begin
                    // Shift the next bit (and after 8 shifts, the next byte) into the MSB.
                    data_d = {data_q[DW-2:0], 1'b0};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StAck;
                end
            end
            StAck: begin
                if (tick && (quarter_q == 2'd1) && i2c_sda_i) err_d = 1'b1;
                if (q3_tick) begin
                    left_d  = left_q - 1'b1;
                    state_d = (err_q || (left_q == PACKET_W'(1))) ? StStop : StBit;
                end
            end
            StStop: if (q3_tick) state_d = StDone;
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus line and done levels for the current quarter, registered on the next edge.
    always_comb begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        done_d = (state_q == StDone);
        case (state_q)
            StStart: begin
                sda_d = (quarter_q == 2'd0);
                scl_d = (quarter_q != 2'd3);
            end
            StBit: begin
                sda_d = data_q[DW-1];
                scl_d = (quarter_q == 2'd1) || (quarter_q == 2'd2);
            end
            StAck: begin
                scl_d = (quarter_q == 2'd1) || (quarter_q == 2'd2);
            end
            StStop: begin
                sda_d = quarter_q[1];
                scl_d = (quarter_q != 2'd0);
            end
            default: ;
        endcase
    end

    assign i2c_scl_o = scl_q;
    assign i2c_sda_o = sda_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_err   = err_q;

endmodule
